shift_reg_left: RTL and testbench
=================================

// Module: shift_reg_left
// PURPOSE
//   Serial-in / parallel-out shift register that shifts toward the MSB.
//   - On each enabled clock edge, din enters at bit 0 and every stored bit moves up one place.
//   - The old MSB is discarded and is also presented on dout for chaining.
//   - Used as a generic deserialiser and as a teaching/datapath building block.
// PARAMETERS
//   WIDTH        4     register length in bits, >= 2
//   RESET_VALUE  '0    value loaded into q while rst is asserted (WIDTH bits)
// PORTS
//   clk     in   1      rising-edge clock; the only clock
//   rst     in   1      reset, asynchronous, active-low (0 = reset)
//   enable  in   1      1 = shift on this edge, 0 = hold
//   din     in   1      serial input, enters q[0]
//   q       out  WIDTH  parallel register contents, q[WIDTH-1] = oldest bit
//   dout    out  1      serial output, equal to q[WIDTH-1] (combinational from q)
// BEHAVIOUR
//   - Reset:
//     - rst low forces q = RESET_VALUE immediately, independent of clk.
//     - q holds that value for as long as rst stays low; enable and din are ignored.
//     - dout follows q[WIDTH-1].
//   - Release: shifting begins on the first rising clk edge at which rst is high.
//   - Shift (rst high, enable high, rising clk):
//     - q <= {q[WIDTH-2:0], din}.
//     - Latency: din appears in q[0] one cycle later and in q[WIDTH-1]/dout WIDTH cycles later.
//   - Hold (rst high, enable low): q unchanged; din is don't-care.
//   - No handshake and no state machine.
//     - enable and din are sampled only at rising clk edges.
//     - Changes between edges have no effect.
//   - Boundaries:
//     - After WIDTH consecutive shifts, q equals the last WIDTH din samples, newest in bit 0.
//     - The bit shifted out of the MSB is lost; there is no wrap-around.
//   - Reset mid-operation: an asserted rst overrides any shift in progress.
//     - An edge coinciding with rst low yields RESET_VALUE.
//   - X/Z on din while enabled propagates into q[0]; it is not filtered.
// STRUCTURE
//   - Single always block: async-reset flop vector plus a shift/hold mux.
//   - dout is a continuous assign.
//   - Shared package: a default WIDTH constant (SHREG_WIDTH_DEFAULT = 4) for benches and instantiations.
//   - No sub-module is required.
//     - An optional per-bit cell `shreg_bit` (flop + enable mux) may be generated WIDTH times.
// TESTING
//   1 Reset:
//     - Drive rst=0, enable=0, din=0 for one cycle -> q=0000, dout=0.
//     - Assert rst between edges -> q clears without waiting for an edge.
//   2 Load sequence, WIDTH=4, rst=1, enable=1:
//     - din=1,0,1,1 on four edges -> q = 0001, 0010, 0101, 1011.
//     - dout=1 after the fourth edge.
//   3 Hold: from q=1011, enable=0 with din toggling for 3 cycles -> q stays 1011.
//   4 Overflow: from 1011, enable=1, din=0 for four edges -> 0110, 1100, 1000, 0000.
//     - dout sequence 0,1,1,0.
//   5 Reset mid-shift:
//     - From q=0101, drive rst low asynchronously mid-cycle -> q=0000 at once.
//     - Release rst, shift din=1 -> q=0001.
//   6 Parameter check: WIDTH=8, RESET_VALUE=8'hA5.
//     - Reset -> q=A5.
//     - Shift din=1 once -> q=4B.

Source files
------------

// File: rtl/shift_reg_left_pkg.sv
// Shared constants for the serial-in / parallel-out left shift register.
package shift_reg_left_pkg;

  localparam int unsigned SHREG_WIDTH_DEFAULT = 4;

endpackage : shift_reg_left_pkg

// File: rtl/shift_reg_left.sv
// Serial-in / parallel-out shift register shifting toward the MSB; the bit
// falling off the top is presented on dout so several instances can be chained.
module shift_reg_left
  import shift_reg_left_pkg::*;
#(
  parameter int unsigned      WIDTH       = SHREG_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic             dout
);

  if (WIDTH < 2) begin : g_width_chk
    $error("shift_reg_left: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] r_q;

  // Reset wins over any shift on a coinciding edge; enable low holds the contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= RESET_VALUE;
    end else if (enable) begin
      r_q <= {r_q[WIDTH-2:0], din};
    end
  end

  assign q    = r_q;
  assign dout = r_q[WIDTH-1];

endmodule : shift_reg_left

// File: tb/tb_shift_reg_left.sv
// Directed and randomized checks of shift_reg_left at WIDTH=4 (zero reset) and WIDTH=8 (reset 8'hA5).
module tb_shift_reg_left;
  import shift_reg_left_pkg::*;

  localparam int unsigned W4 = SHREG_WIDTH_DEFAULT;
  localparam int unsigned W8 = 8;
  localparam logic [W8-1:0] RV8 = 8'hA5;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          din;
  logic [W4-1:0] q4;
  logic          dout4;
  logic [W8-1:0] q8;
  logic          dout8;

  int checks;
  int errors;

  // Reference: register value as an integer; a shift is "times two plus din, modulo 2**W".
  longint m4;
  longint m8;

  shift_reg_left #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .q(q4), .dout(dout4)
  );

  shift_reg_left #(.WIDTH(W8), .RESET_VALUE(RV8)) u_dut8 (
    .clk(clk), .rst(rst), .enable(enable), .din(din), .q(q8), .dout(dout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_q4"},    32'(q4),    32'(m4));
    chk({tag, "_dout4"}, 32'(dout4), 32'(m4 / 8));
    chk({tag, "_q8"},    32'(q8),    32'(m8));
    chk({tag, "_dout8"}, 32'(dout8), 32'(m8 / 128));
  endtask

  // Inputs are applied away from the edge, the edge is taken, outputs sampled 1 time unit later.
  task automatic step(input logic en, input logic d);
    enable = en;
    din    = d;
    @(posedge clk);
    if (rst && en) begin
      m4 = (m4 * 2 + longint'(d)) % 16;
      m8 = (m8 * 2 + longint'(d)) % 256;
    end else if (!rst) begin
      m4 = 0;
      m8 = longint'(RV8);
    end
    #1;
  endtask

  task automatic async_reset_pulse(input string tag);
    #2;
    rst = 1'b0;
    #1;
    m4 = 0;
    m8 = longint'(RV8);
    chk_all(tag);
    rst = 1'b1;
  endtask

  initial begin
    logic [W4-1:0] load_exp [4];
    logic          load_din [4];
    logic [W4-1:0] ovf_exp  [4];
    logic          ovf_dout [4];

    checks = 0;
    errors = 0;
    rst    = 1'b0;
    enable = 1'b0;
    din    = 1'b0;
    m4     = 0;
    m8     = longint'(RV8);

    load_din = '{1'b1, 1'b0, 1'b1, 1'b1};
    load_exp = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    ovf_exp  = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
    ovf_dout = '{1'b0, 1'b1, 1'b1, 1'b0};

    // Reset with enable=0, din=0 for one cycle.
    step(1'b0, 1'b0);
    chk("reset_q4", 32'(q4), 32'h0);
    chk("reset_dout4", 32'(dout4), 32'h0);
    chk("reset_q8", 32'(q8), 32'hA5);
    chk("reset_dout8", 32'(dout8), 32'h1);

    // An edge while rst is low with enable=1, din=1 must still leave the reset value.
    step(1'b1, 1'b1);
    chk("reset_edge_q4", 32'(q4), 32'h0);
    chk("reset_edge_q8", 32'(q8), 32'hA5);

    rst = 1'b1;

    // Load sequence 1,0,1,1.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, load_din[i]);
      chk($sformatf("load%0d_q4", i), 32'(q4), 32'(load_exp[i]));
      chk_all($sformatf("load%0d", i));
    end
    chk("load_dout4", 32'(dout4), 32'h1);

    // Hold with din toggling.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, logic'(i % 2 == 0));
      chk($sformatf("hold%0d_q4", i), 32'(q4), 32'hB);
      chk_all($sformatf("hold%0d", i));
    end

    // Mid-cycle din glitch must not matter: din returns to its value before the edge.
    enable = 1'b1;
    din    = 1'b1;
    #2;
    din    = 1'b0;
    #1;
    chk("glitch_noedge_q4", 32'(q4), 32'hB);

    // Overflow: shift zeros in, old bits fall off the MSB.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("ovf%0d_q4", i), 32'(q4), 32'(ovf_exp[i]));
      chk($sformatf("ovf%0d_dout4", i), 32'(dout4), 32'(ovf_dout[i]));
      chk_all($sformatf("ovf%0d", i));
    end

    // Build q4=0101, then reset asynchronously between edges.
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("pre_async_q4", 32'(q4), 32'h5);
    async_reset_pulse("async_mid");
    chk("async_mid_q4_const", 32'(q4), 32'h0);
    chk("async_mid_q8_const", 32'(q8), 32'hA5);
    step(1'b1, 1'b1);
    chk("post_async_q4", 32'(q4), 32'h1);
    chk("w8_shift_q8", 32'(q8), 32'h4B);
    chk_all("post_async");

    // Randomized enable/din with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      step(logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)));
      chk_all($sformatf("rnd%0d", i));
      if ($urandom_range(0, 19) == 0) begin
        async_reset_pulse($sformatf("rnd_rst%0d", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_reg_left
